// File: rtl/sccb_config.sv
// SCCB write-only master that streams the OV7670 register table after start.
// Optional NACK detection on the 9th bit is enabled by defining SCCB_ACK_CHECK_EN.
module sccb_config #(
  parameter int unsigned CLK_DIV      = 60,
  parameter int unsigned DELAY_CYCLES = 24000,
  parameter int unsigned GAP_Q        = 8,
  parameter logic [7:0]  DEV_ID       = 8'h42
) (
  input  logic       CLOCK_24,
  input  logic       rst,
  input  logic       start,
  output logic       sio_c,
  output logic       sio_d_out,
  output logic       sio_d_oe,
  input  logic       sio_d_in,
  output logic       busy,
  output logic       done,
  output logic [3:0] index,
  output logic       err
);

  localparam int unsigned QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DELAY, S_START, S_BYTE, S_STOP, S_GAP, S_DONE
  } state_t;

  state_t          state;
  logic [QW-1:0]   qcnt;
  logic [3:0]      q;
  logic [DW-1:0]   dcnt;
  logic [3:0]      bitn;
  logic [1:0]      byten;
  logic [7:0]      sh;
  logic [7:0]      addr_r;
  logic [7:0]      data_r;
  logic            first;
  logic            nack;
  logic            ack_in;
  logic            qwrap;
  logic [2:0]      ld_idx;
  logic [15:0]     entry;
  logic [7:0]      next_byte;

`ifdef SCCB_ACK_CHECK_EN
  assign ack_in = sio_d_in;
`else
  logic unused_sio_d_in;
  assign unused_sio_d_in = sio_d_in;
  assign ack_in          = 1'b0;
`endif

  function automatic logic [15:0] table_entry(input logic [2:0] i);
    case (i)
      3'd0: return 16'h1280;
      3'd1: return 16'hFF00;
      3'd2: return 16'h1200;
      3'd3: return 16'h1101;
      3'd4: return 16'h40C0;
      3'd5: return 16'h3A04;
      3'd6: return 16'h8C00;
      3'd7: return 16'h0C00;
    endcase
  endfunction

  // The first LOAD after start fetches entry 0; later LOADs advance and saturate at 7.
  always_comb begin
    ld_idx = 3'd0;
    if (!first) ld_idx = (index[2:0] == 3'd7) ? 3'd7 : index[2:0] + 3'd1;
    entry     = table_entry(ld_idx);
    next_byte = (byten == 2'd0) ? addr_r : data_r;
    qwrap     = (qcnt == QW'(CLK_DIV - 1));
  end

  always_ff @(posedge CLOCK_24) begin
    if (rst) begin
      state     <= S_IDLE;
      qcnt      <= '0;
      q         <= '0;
      dcnt      <= '0;
      bitn      <= '0;
      byten     <= '0;
      sh        <= '0;
      addr_r    <= '0;
      data_r    <= '0;
      first     <= 1'b0;
      nack      <= 1'b0;
      sio_c     <= 1'b1;
      sio_d_out <= 1'b1;
      sio_d_oe  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      index     <= '0;
      err       <= 1'b0;
    end else begin
      if (state inside {S_START, S_BYTE, S_STOP, S_GAP})
        qcnt <= qwrap ? '0 : qcnt + QW'(1);
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state <= S_LOAD;
            busy  <= 1'b1;
            done  <= 1'b0;
            err   <= 1'b0;
            index <= '0;
            first <= 1'b1;
          end
        end
        S_LOAD: begin
          first  <= 1'b0;
          index  <= {1'b0, ld_idx};
          addr_r <= entry[15:8];
          data_r <= entry[7:0];
          qcnt   <= '0;
          q      <= '0;
          dcnt   <= '0;
          nack   <= 1'b0;
          state  <= (entry[15:8] == 8'hFF) ? S_DELAY : S_START;
        end
        S_DELAY: begin
          if (dcnt == DW'(DELAY_CYCLES - 1)) begin
            if (index[2:0] == 3'd7) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= S_LOAD;
            end
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        S_START: begin
          if (qwrap) begin
            if (q == 4'd0) begin
              q         <= 4'd1;
              sio_d_out <= 1'b0;
            end else begin
              state     <= S_BYTE;
              q         <= '0;
              bitn      <= '0;
              byten     <= '0;
              sio_c     <= 1'b0;
              sio_d_out <= DEV_ID[7];
              sh        <= {DEV_ID[6:0], 1'b0};
            end
          end
        end
        S_BYTE: begin
          if (qwrap) begin
            case (q)
              4'd0: q <= 4'd1;
              4'd1: begin
                q     <= 4'd2;
                sio_c <= 1'b1;
                if (bitn == 4'd8) nack <= ack_in;
              end
              4'd2: q <= 4'd3;
              default: begin
                q     <= 4'd0;
                sio_c <= 1'b0;
                if (bitn == 4'd7) begin
                  bitn     <= 4'd8;
                  sio_d_oe <= 1'b0;
                end else if (bitn == 4'd8) begin
                  sio_d_oe <= 1'b1;
                  if (nack || byten == 2'd2) begin
                    state     <= S_STOP;
                    sio_d_out <= 1'b0;
                  end else begin
                    byten     <= byten + 2'd1;
                    bitn      <= '0;
                    sio_d_out <= next_byte[7];
                    sh        <= {next_byte[6:0], 1'b0};
                  end
                end else begin
                  bitn      <= bitn + 4'd1;
                  sio_d_out <= sh[7];
                  sh        <= {sh[6:0], 1'b0};
                end
              end
            endcase
          end
        end
        S_STOP: begin
          if (qwrap) begin
            if (q == 4'd0) begin
              q     <= 4'd1;
              sio_c <= 1'b1;
            end else if (q == 4'd1) begin
              q         <= 4'd2;
              sio_d_out <= 1'b1;
            end else begin
              q <= '0;
              if (nack) begin
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                err   <= 1'b1;
              end else begin
                state <= S_GAP;
              end
            end
          end
        end
        S_GAP: begin
          if (qwrap) begin
            if (q == 4'(GAP_Q - 1)) begin
              q <= '0;
              if (index[2:0] == 3'd7) begin
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= S_LOAD;
              end
            end else begin
              q <= q + 4'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_config.sv
// Directed bench for sccb_config: decodes the SCCB bus and checks bytes, timing and control flags.
module tb_sccb_config;

  localparam int unsigned Q  = 4;
  localparam int unsigned DC = 200;
  localparam int unsigned GQ = 8;

  logic       CLOCK_24 = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       sio_c, sio_d_out, sio_d_oe, sio_d_in;
  logic       busy, done, err;
  logic [3:0] index;

  sccb_config #(.CLK_DIV(Q), .DELAY_CYCLES(DC), .GAP_Q(GQ), .DEV_ID(8'h42)) dut (
    .CLOCK_24 (CLOCK_24),
    .rst      (rst),
    .start    (start),
    .sio_c    (sio_c),
    .sio_d_out(sio_d_out),
    .sio_d_oe (sio_d_oe),
    .sio_d_in (sio_d_in),
    .busy     (busy),
    .done     (done),
    .index    (index),
    .err      (err)
  );

  always #5 CLOCK_24 = ~CLOCK_24;

  int n_assert = 0;
  int n_fail   = 0;

  // bus monitor state
  bit         mon_clr = 1'b0;
  bit         nack_mode = 1'b0;
  int         cyc = 0;
  int         tr_num, bits, stops, bad_period, bad_high, n_meas, max_quiet;
  int         last_edge, last_rise, prev_rise;
  bit         in_tr, pend, have_edge, have_prev_rise;
  logic       p_c, p_d, pend_bit;
  logic [8:0] sh9;
  logic [7:0] byteq[$];

  // Slave: ACKs every byte except the sub-address of the 4th transaction when nack_mode is set.
  assign sio_d_in = sio_d_oe ? sio_d_out
                  : ((nack_mode && tr_num == 4 && bits == 17) ? 1'b1 : 1'b0);

  always @(negedge CLOCK_24) begin
    cyc++;
    if (mon_clr) begin
      tr_num = 0; bits = 0; stops = 0; bad_period = 0; bad_high = 0; n_meas = 0;
      max_quiet = 0; in_tr = 0; pend = 0; have_edge = 0; have_prev_rise = 0;
      sh9 = '0; byteq.delete();
    end else begin
      if (sio_c !== p_c) begin
        if (have_edge && (cyc - last_edge) > max_quiet) max_quiet = cyc - last_edge;
        last_edge = cyc;
        have_edge = 1;
      end
      if (sio_c && p_c && p_d && !sio_d_out && sio_d_oe) begin
        in_tr = 1; tr_num++; bits = 0; pend = 0; have_prev_rise = 0;
      end else if (sio_c && p_c && !p_d && sio_d_out && sio_d_oe) begin
        in_tr = 0; pend = 0; stops++;
      end else if (sio_c && !p_c) begin
        if (in_tr) begin
          pend = 1; pend_bit = sio_d_out; last_rise = cyc;
        end
      end else if (!sio_c && p_c) begin
        if (in_tr && pend) begin
          pend = 0;
          n_meas++;
          if ((cyc - last_rise) != 2 * Q) bad_high++;
          if (have_prev_rise && (last_rise - prev_rise) != 4 * Q) bad_period++;
          prev_rise = last_rise;
          have_prev_rise = 1;
          sh9 = {sh9[7:0], pend_bit};
          bits++;
          if (bits % 9 == 0) byteq.push_back(sh9[8:1]);
        end
      end
    end
    p_c = sio_c;
    p_d = sio_d_out;
  end

  logic [7:0] exp_bytes [21] = '{8'h42, 8'h12, 8'h80, 8'h42, 8'h12, 8'h00, 8'h42, 8'h11, 8'h01,
                                 8'h42, 8'h40, 8'hC0, 8'h42, 8'h3A, 8'h04, 8'h42, 8'h8C, 8'h00,
                                 8'h42, 8'h0C, 8'h00};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge CLOCK_24);
    @(negedge CLOCK_24);
    mon_clr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge CLOCK_24);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge CLOCK_24);
      n++;
    end
    ok = (done === 1'b1);
  endtask

  task automatic check_full_table(input string tag);
    check({tag, "_stops"}, stops, 7);
    check({tag, "_nbytes"}, byteq.size(), 21);
    for (int i = 0; i < 21 && i < byteq.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), byteq[i], exp_bytes[i]);
  endtask

  initial begin
    bit ok;
    int cnt;

    // reset state
    rst = 1'b1;
    repeat (3) @(negedge CLOCK_24);
    check("rst_sio_c", sio_c, 1);
    check("rst_sio_d", sio_d_out, 1);
    check("rst_oe", sio_d_oe, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_index", index, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    @(negedge CLOCK_24);

    // run 1: start latency, bus decode, timing, delay entry
    clear_mon();
    pulse_start();
    check("start_busy", busy, 1);
    cnt = 0;
    while (sio_d_out === 1'b1 && cnt < 1000) begin
      @(negedge CLOCK_24);
      cnt++;
    end
    check("start_d_fall_cycles", cnt, Q + 1);
    check("start_c_high", sio_c, 1);
    wait_done(20000, ok);
    check("run1_done_timeout", ok, 1);
    check("run1_busy", busy, 0);
    check("run1_index", index, 7);
    check("run1_err", err, 0);
    check_full_table("run1");
    check("run1_bits_measured", n_meas, 7 * 27);
    check("run1_bad_high", bad_high, 0);
    check("run1_bad_period", bad_period, 0);
    check("run1_delay_quiet", max_quiet, 12 * Q + DC + 2);

    // run 2: restart from DONE; a second start while busy is ignored
    clear_mon();
    pulse_start();
    check("run2_done_cleared", done, 0);
    repeat (100) @(negedge CLOCK_24);
    pulse_start();
    check("run2_busy_ignored_start", busy, 1);
    check("run2_index_ignored_start", index, 0);
    wait_done(20000, ok);
    check("run2_done_timeout", ok, 1);
    check("run2_index", index, 7);
    check_full_table("run2");

    // run 3: reset mid-byte of entry 3, then reset beats start
    clear_mon();
    pulse_start();
    cnt = 0;
    while (index !== 4'd3 && cnt < 20000) begin
      @(negedge CLOCK_24);
      cnt++;
    end
    check("run3_reach_entry3", index, 3);
    repeat (100) @(negedge CLOCK_24);
    check("run3_in_transfer", busy, 1);
    rst = 1'b1;
    @(negedge CLOCK_24);
    check("midrst_sio_c", sio_c, 1);
    check("midrst_oe", sio_d_oe, 1);
    check("midrst_sio_d", sio_d_out, 1);
    check("midrst_busy", busy, 0);
    check("midrst_index", index, 0);
    check("midrst_done", done, 0);
    start = 1'b1;
    @(negedge CLOCK_24);
    start = 1'b0;
    rst = 1'b0;
    check("rst_beats_start_busy", busy, 0);
    repeat (10) @(negedge CLOCK_24);
    check("rst_beats_start_idle", busy, 0);

    // run 4: slave NACKs the sub-address of entry 4
    nack_mode = 1'b1;
    clear_mon();
    pulse_start();
    wait_done(20000, ok);
    check("nack_done_timeout", ok, 1);
    check("nack_busy", busy, 0);
`ifdef SCCB_ACK_CHECK_EN
    check("nack_err", err, 1);
    check("nack_index", index, 4);
    check("nack_stops", stops, 4);
    check("nack_nbytes", byteq.size(), 11);
`else
    check("nack_err", err, 0);
    check("nack_index", index, 7);
    check_full_table("nack");
`endif

    // run 5: a fresh start clears err and completes with an ACKing slave
    nack_mode = 1'b0;
    clear_mon();
    pulse_start();
    check("run5_err_cleared", err, 0);
    check("run5_busy", busy, 1);
    wait_done(20000, ok);
    check("run5_done_timeout", ok, 1);
    check("run5_err", err, 0);
    check("run5_index", index, 7);
    check("run5_stops", stops, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
